// File: rtl/kn_window_detector_if.sv
// Serial-sample / detector-status bundle for kn_window_detector.
// The master drives samples; the slave is the detector.
interface kn_window_detector_if #(
   parameter int WIN   = 9,
   parameter int LEN_W = 16
);
   localparam int CW = $clog2(WIN + 1);

   logic             dataIn;
   logic             detect;
   logic             begP;
   logic             endP;
   logic [CW-1:0]    win_cnt;
   logic [LEN_W-1:0] pkt_len;

   modport master (
      output dataIn,
      input  detect, begP, endP, win_cnt, pkt_len
   );

   modport slave (
      input  dataIn,
      output detect, begP, endP, win_cnt, pkt_len
   );
endinterface

// File: rtl/kn_window_detector.sv
// K-of-N sliding-window pulse detector with zero-run or window-count end hysteresis.
// Optional packet length output enabled by defining KN_LEN_OUT_EN.
module kn_window_detector #(
   parameter int WIN       = 9,
   parameter int K_BEG     = 5,
   parameter int END_ZEROS = 2,
   parameter int LEN_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   kn_window_detector_if.slave  bus
);
   localparam int            CW  = $clog2(WIN + 1);
   localparam logic [CW-1:0] K_C = CW'(K_BEG);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t         r_state;
   logic [WIN-1:0] r_win;
   logic [CW-1:0]  r_cnt;
   logic [4:0]     r_zrun;
   logic           r_detect;
   logic           r_begP;
   logic           r_endP;

   logic [WIN-1:0] w_win_shift;
   logic           w_drop;
   logic [CW-1:0]  w_cnt_nxt;
   logic [4:0]     w_zrun_nxt;
   logic           w_start;
   logic           w_stop;
   logic           w_flush;

   generate
      if (WIN == 1) begin : g_win1
         assign w_win_shift = bus.dataIn;
      end else begin : g_winn
         assign w_win_shift = {r_win[WIN-2:0], bus.dataIn};
      end
   endgenerate

   // Count after this edge: add the incoming sample, drop the oldest one.
   assign w_drop     = r_win[WIN-1];
   assign w_cnt_nxt  = r_cnt + CW'(bus.dataIn) - CW'(w_drop);
   assign w_zrun_nxt = bus.dataIn ? 5'd0 : r_zrun + 5'd1;
   assign w_start    = (r_state == IDLE) && (w_cnt_nxt >= K_C);

   generate
      if (END_ZEROS > 0) begin : g_zrun_end
         localparam logic [4:0] EZ_C = 5'(END_ZEROS);
         assign w_stop  = (r_state == ACTIVE) && (w_zrun_nxt == EZ_C);
         // Flushing on the end edge keeps the tail of the packet from re-arming begin.
         assign w_flush = w_stop;
      end else begin : g_win_end
         assign w_stop  = (r_state == ACTIVE) && (w_cnt_nxt < K_C);
         assign w_flush = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_win    <= '0;
         r_cnt    <= '0;
         r_zrun   <= '0;
         r_detect <= 1'b0;
         r_begP   <= 1'b0;
         r_endP   <= 1'b0;
      end else begin
         r_begP <= 1'b0;
         r_endP <= 1'b0;
         r_win  <= w_flush ? '0 : w_win_shift;
         r_cnt  <= w_flush ? '0 : w_cnt_nxt;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state  <= ACTIVE;
                  r_detect <= 1'b1;
                  r_begP   <= 1'b1;
                  r_zrun   <= '0;
               end
            end
            ACTIVE: begin
               r_zrun <= w_zrun_nxt;
               if (w_stop) begin
                  r_state  <= IDLE;
                  r_detect <= 1'b0;
                  r_endP   <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.detect  = r_detect;
   assign bus.begP    = r_begP;
   assign bus.endP    = r_endP;
   assign bus.win_cnt = r_cnt;

`ifdef KN_LEN_OUT_EN
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_pkt_len;
   logic [LEN_W-1:0] w_len_inc;

   assign w_len_inc = (&r_len) ? r_len : r_len + LEN_W'(1);

   // Length includes both the begin and the end sample; a reset abort never publishes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_len     <= '0;
         r_pkt_len <= '0;
      end else if (w_start) begin
         r_len <= LEN_W'(1);
      end else if (r_state == ACTIVE) begin
         r_len <= w_len_inc;
         if (w_stop) r_pkt_len <= w_len_inc;
      end
   end

   assign bus.pkt_len = r_pkt_len;
`else
   assign bus.pkt_len = {LEN_W{1'b0}};
`endif

   a_no_overlap: assert property (@(posedge clk) disable iff (reset) !(r_begP && r_endP));

endmodule

// File: tb/tb_kn_window_detector.sv
// Scoreboard bench: one sample stream feeds five differently configured detectors,
// each compared against a window/history reference model.
module tb_kn_window_detector;
   localparam int NI = 5;

   function automatic int cfg_win(input int g);
      case (g) 0: return 5; 1: return 9; 2: return 7; 3: return 7; default: return 1; endcase
   endfunction
   function automatic int cfg_k(input int g);
      case (g) 0: return 5; 1: return 5; 2: return 4; 3: return 4; default: return 1; endcase
   endfunction
   function automatic int cfg_ez(input int g);
      case (g) 2: return 2; 3: return 2; default: return 0; endcase
   endfunction
   function automatic int cfg_lw(input int g);
      return (g == 3) ? 4 : 16;
   endfunction

`ifdef KN_LEN_OUT_EN
   localparam int LEN_ON = 1;
`else
   localparam int LEN_ON = 0;
`endif

   typedef struct packed {
      logic [NI-1:0]       det;
      logic [NI-1:0]       beg;
      logic [NI-1:0]       endp;
      logic [NI-1:0][5:0]  wc;
      logic [NI-1:0][15:0] pl;
   } exp_t;

   logic clk;
   logic rst;
   logic din;
   logic [NI-1:0]       a_det, a_beg, a_end;
   logic [NI-1:0][5:0]  a_wc;
   logic [NI-1:0][15:0] a_pl;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      kn_window_detector_if #(.WIN(cfg_win(g)), .LEN_W(cfg_lw(g))) bus ();
      kn_window_detector #(
         .WIN(cfg_win(g)), .K_BEG(cfg_k(g)), .END_ZEROS(cfg_ez(g)), .LEN_W(cfg_lw(g))
      ) u_dut (
         .clk   (clk),
         .reset (rst),
         .bus   (bus)
      );
      assign bus.dataIn = din;
      assign a_det[g]   = bus.detect;
      assign a_beg[g]   = bus.begP;
      assign a_end[g]   = bus.endP;
      assign a_wc[g]    = 6'(bus.win_cnt);
      assign a_pl[g]    = 16'(bus.pkt_len);
   end

   // Reference model: explicit sample history, ones counted over the last WIN samples.
   bit m_hist [NI][32];
   bit m_act  [NI];
   int m_zr   [NI];
   int m_len  [NI];
   int m_plen [NI];

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < 32; k++) m_hist[i][k] = 1'b0;
         m_act[i] = 1'b0; m_zr[i] = 0; m_len[i] = 0; m_plen[i] = 0;
      end
   endtask

   task automatic model_step(input bit b, output exp_t e);
      e = '0;
      for (int i = 0; i < NI; i++) begin
         int ones;
         bit beg_e;
         bit end_e;
         ones = 0; beg_e = 1'b0; end_e = 1'b0;
         for (int k = 31; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
         m_hist[i][0] = b;
         for (int k = 0; k < cfg_win(i); k++) ones += int'(m_hist[i][k]);
         if (!m_act[i]) begin
            if (ones >= cfg_k(i)) begin
               m_act[i] = 1'b1; beg_e = 1'b1; m_zr[i] = 0; m_len[i] = 1;
            end
         end else begin
            if (m_len[i] < (1 << cfg_lw(i)) - 1) m_len[i]++;
            if (cfg_ez(i) > 0) begin
               m_zr[i] = b ? 0 : m_zr[i] + 1;
               if (m_zr[i] == cfg_ez(i)) begin
                  end_e = 1'b1;
                  for (int k = 0; k < 32; k++) m_hist[i][k] = 1'b0;
                  ones = 0;
               end
            end else if (ones < cfg_k(i)) begin
               end_e = 1'b1;
            end
            if (end_e) begin
               m_act[i] = 1'b0;
               m_plen[i] = m_len[i];
            end
         end
         e.det[i]  = m_act[i];
         e.beg[i]  = beg_e;
         e.endp[i] = end_e;
         e.wc[i]   = 6'(ones);
         e.pl[i]   = (LEN_ON != 0) ? 16'(m_plen[i]) : 16'd0;
      end
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && q.size() > 0) begin
         e = q.pop_front();
         for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (a_det[i] !== e.det[i] || a_beg[i] !== e.beg[i] || a_end[i] !== e.endp[i] ||
                a_wc[i] !== e.wc[i] || a_pl[i] !== e.pl[i]) begin
               n_fail++;
               $display("FAIL scoreboard inst%0d t=%0t: got det=%b beg=%b end=%b wc=%0d len=%0d, want det=%b beg=%b end=%b wc=%0d len=%0d",
                        i, $time, a_det[i], a_beg[i], a_end[i], a_wc[i], a_pl[i],
                        e.det[i], e.beg[i], e.endp[i], e.wc[i], e.pl[i]);
            end
         end
      end
   end

   // Called at posedge+1; returns at the next posedge+1 with the model advanced.
   task automatic step(input bit b);
      exp_t e;
      din = b;
      @(posedge clk);
      #1;
      model_step(b, e);
      q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      din = 1'b0;
      model_reset();
      #2;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset_det%0d", i), int'(a_det[i]), 0);
         chk($sformatf("reset_wc%0d", i), int'(a_wc[i]), 0);
         chk($sformatf("reset_len%0d", i), int'(a_pl[i]), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 5/5 window mode; WIN=1 follower rides along on the same stream.
      do_reset();
      for (int n = 0; n < 5; n++) step(1'b1);
      chk("t1_beg", int'(a_beg[0]), 1);
      chk("t1_wc5", int'(a_wc[0]), 5);
      chk("t1_w1_det", int'(a_det[4]), 1);
      step(1'b0);
      chk("t1_end", int'(a_end[0]), 1);
      chk("t1_det0", int'(a_det[0]), 0);
      chk("t1_wc4", int'(a_wc[0]), 4);
      chk("t1_w1_end", int'(a_end[4]), 1);

      // 5/9 alternating pattern.
      do_reset();
      for (int n = 0; n < 9; n++) step(n % 2 == 0);
      chk("t2_beg", int'(a_beg[1]), 1);
      chk("t2_wc5", int'(a_wc[1]), 5);
      step(1'b0);
      chk("t2_end", int'(a_end[1]), 1);
      chk("t2_wc4", int'(a_wc[1]), 4);

      // 4/7-2: 4 ones, then 0,1,0,0.
      do_reset();
      for (int n = 0; n < 4; n++) step(1'b1);
      chk("t3_beg", int'(a_beg[2]), 1);
      step(1'b0); step(1'b1); step(1'b0);
      chk("t3_still_det", int'(a_det[2]), 1);
      step(1'b0);
      chk("t3_end", int'(a_end[2]), 1);
      chk("t3_len", int'(a_pl[2]), LEN_ON ? 5 : 0);
      step(1'b0);
      chk("t3_flush_wc", int'(a_wc[2]), 0);

      // Back-to-back packets, no re-trigger after the flush.
      do_reset();
      for (int n = 0; n < 4; n++) step(1'b1);
      step(1'b0); step(1'b0);
      chk("t4_end1", int'(a_end[2]), 1);
      step(1'b1);
      chk("t4_no_retrig", int'(a_det[2]), 0);
      step(1'b1); step(1'b1); step(1'b1);
      chk("t4_beg2", int'(a_beg[2]), 1);
      step(1'b0); step(1'b0);
      chk("t4_end2", int'(a_end[2]), 1);

      // Mid-packet asynchronous reset.
      for (int n = 0; n < 4; n++) step(1'b1);
      chk("t5_det_before", int'(a_det[2]), 1);
      rst = 1'b1;
      q.delete();
      model_reset();
      #1;
      chk("t5_det_async", int'(a_det[2]), 0);
      chk("t5_wc_async", int'(a_wc[2]), 0);
      chk("t5_len_async", int'(a_pl[2]), 0);
      #4;
      rst = 1'b0;
      step(1'b0);
      chk("t5_no_endp", int'(a_end[2]), 0);
      step(1'b0);

      // Long packet: LEN_W=4 saturates, LEN_W=16 does not.
      do_reset();
      for (int n = 0; n < 20; n++) step(1'b1);
      step(1'b0); step(1'b0);
      chk("t6_end", int'(a_end[3]), 1);
      chk("t6_sat", int'(a_pl[3]), LEN_ON ? 15 : 0);
      chk("t6_nosat", int'(a_pl[2]), LEN_ON ? 19 : 0);

      // Randomized bursts with varying density and occasional resets.
      begin
         int p;
         p = 50;
         for (int n = 0; n < 3000; n++) begin
            if (n % 16 == 0) begin
               case ($urandom_range(3))
                  0: p = 5; 1: p = 40; 2: p = 75; default: p = 97;
               endcase
            end
            if ($urandom_range(499) == 0) do_reset();
            else step($urandom_range(99) < p);
         end
      end

      for (int n = 0; n < 12; n++) step(1'b0);
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/kn_window_detector.md
Name: kn_window_detector

Overview:
Parametrised K-of-N sliding-window pulse detector with begin/end hysteresis. It is the single-module successor of the fixed 5/5, 5/9 and 4/7-2 detectors in top. One serial input bit is sampled per clock. The detector raises a level "detect" while a packet is present and emits one-cycle begin/end markers. Any of the legacy detectors is obtained by parameter choice: 5/5 is WIN=5, K_BEG=5, END_ZEROS=0; 5/9 is WIN=9, K_BEG=5, END_ZEROS=0; 4/7-2 is WIN=7, K_BEG=4, END_ZEROS=2.

Parameters:
WIN, 9, sliding window length in samples; legal range 1..32.
K_BEG, 5, begin threshold: number of ones in the window; legal range 1..WIN.
END_ZEROS, 2, consecutive zeros that end a packet; 0 selects window mode (end when window count < K_BEG); legal range 0..15.
LEN_W, 16, width of the packet length counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
dataIn  in  1  serial data sample, one per clock.
detect  out  1  high while a packet is active.
begP  out  1  one-cycle pulse on the edge where detect rises.
endP  out  1  one-cycle pulse on the edge where detect falls.
win_cnt  out  $clog2(WIN+1)  number of ones currently in the window.
pkt_len  out  LEN_W  length of the last completed packet (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high): window shift register = 0, win_cnt = 0, zero-run counter = 0, state = IDLE, detect = 0, begP = 0, endP = 0, pkt_len = 0. Reset mid-packet aborts the packet: no endP is emitted and pkt_len is not updated.
- Every rising edge: dataIn shifts into the WIN-bit window; the oldest bit drops out. win_cnt is updated incrementally (+dataIn, -dropped bit). win_cnt always reflects the window including the sample taken at that edge.
- All outputs are registered. A decision is visible in the cycle after the edge that sampled the deciding bit.
- FSM has two states: IDLE and ACTIVE.
- IDLE -> ACTIVE: on the edge where the new win_cnt >= K_BEG. On that edge detect <= 1, begP <= 1 (for one cycle only), zero-run counter <= 0, length counter <= 1.
- ACTIVE, END_ZEROS > 0: a zero sample increments the zero-run counter; a one sample clears it. When the counter reaches END_ZEROS, go to IDLE: detect <= 0, endP <= 1 (one cycle), and the window is flushed to all zeros so win_cnt = 0 on the next cycle. This prevents immediate re-triggering.
- ACTIVE, END_ZEROS = 0: go to IDLE on the edge where the new win_cnt < K_BEG. No flush is performed.
- Length counter increments on every ACTIVE edge, including the ending edge, and saturates at 2^LEN_W-1.
- begP and endP are never high in the same cycle.
- Back-to-back packets: the earliest re-entry into ACTIVE is the edge after endP.
- WIN = K_BEG = 1 with END_ZEROS = 0: detect follows dataIn with a one-cycle delay; begP and endP mark its edges.
- dataIn equal to X/Z is not supported; the bench drives 0 or 1 only.

Optional Feature:
- Macro: KN_LEN_OUT_EN.
- When defined: on the endP edge, pkt_len <= the length counter (the sample count from the begin edge to the end edge, inclusive). pkt_len holds that value until the next endP or reset.
- When not defined: the length counter is not built and pkt_len is tied to 0.

Test Plan:
1. WIN=5, K_BEG=5, END_ZEROS=0: reset, then 5 ones, then a 0 -> detect=1 and begP=1 in the cycle after the 5th sampling edge; detect=0 and endP=1 after the 0; win_cnt reads 5 then 4.
2. WIN=9, K_BEG=5, END_ZEROS=0: pattern 1,0,1,0,1,0,1,0,1 -> begP after the 9th edge; following zeros -> endP after the next dropped 1 (win_cnt 4).
3. WIN=7, K_BEG=4, END_ZEROS=2: 4 ones, then 0,1,0,0 -> begP after the 4th edge, endP after the last 0, win_cnt=0 the next cycle; pkt_len=5 with KN_LEN_OUT_EN defined, 0 without.
4. Same configuration: 4 ones, 0,0, then 4 ones -> two separate begP/endP pairs; no re-trigger in the cycle after endP.
5. Assert reset for half a cycle mid-packet (detect=1) -> detect, win_cnt and pkt_len go to 0 immediately (asynchronously); no endP pulse.
6. LEN_W=4 with a 20-sample all-ones packet -> pkt_len saturates at 15.
